// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALU-control decode, single-cycle datapath and an iterative
// multiply/divide engine that owns the HI/LO registers and stalls the pipe while busy.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  typedef enum logic [4:0] {
    OpAdd, OpAddu, OpSub, OpSubu, OpAnd, OpOr, OpXor, OpNor,
    OpSll, OpSrl, OpSra, OpSlt, OpSltu,
    OpMfhi, OpMflo, OpMthi, OpMtlo,
    OpMult, OpMultu, OpDiv, OpDivu
  } op_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div0_q, div0_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  op_e                op;
  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   sum, diff, res;
  logic               add_ovf, sub_ovf;
  logic [W2-1:0]      acc_nx, prod;

  // One shift-add step: {upper partial product, remaining multiplier bits}.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] acc,
                                             input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] s;
    s = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {s, acc[WIDTH-1:1]};
  endfunction

  // One restoring step: {partial remainder, dividend bits shifting into quotient}.
  function automatic logic [W2-1:0] div_step(input logic [W2-1:0] acc,
                                             input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] d;
    rem_sh = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    d      = rem_sh - {1'b0, dvsr};
    if (!d[WIDTH]) return {d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else           return {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    op = OpAnd;
    case (alu_op)
      2'b00:   op = OpAdd;
      2'b01:   op = OpSub;
      2'b11:   op = OpOr;
      default: begin
        case (funct)
          6'b100000: op = OpAdd;
          6'b100001: op = OpAddu;
          6'b100010: op = OpSub;
          6'b100011: op = OpSubu;
          6'b100100: op = OpAnd;
          6'b100101: op = OpOr;
          6'b100110: op = OpXor;
          6'b100111: op = OpNor;
          6'b000000: op = OpSll;
          6'b000010: op = OpSrl;
          6'b000011: op = OpSra;
          6'b101010: op = OpSlt;
          6'b101011: op = OpSltu;
          6'b010000: op = OpMfhi;
          6'b010010: op = OpMflo;
          6'b010001: op = OpMthi;
          6'b010011: op = OpMtlo;
          6'b011000: op = OpMult;
          6'b011001: op = OpMultu;
          6'b011010: op = OpDiv;
          6'b011011: op = OpDivu;
          default:   op = OpAnd;
        endcase
      end
    endcase
  end

  assign sgn     = (op == OpMult) || (op == OpDiv);
  assign mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b   = (sgn && b[WIDTH-1]) ? -b : b;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res = a & b;
    case (op)
      OpAdd, OpAddu: res = sum;
      OpSub, OpSubu: res = diff;
      OpOr:          res = a | b;
      OpXor:         res = a ^ b;
      OpNor:         res = ~(a | b);
      OpSll:         res = b << shamt;
      OpSrl:         res = b >> shamt;
      OpSra:         res = $signed(b) >>> shamt;
      OpSlt:         res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu:        res = {{(WIDTH-1){1'b0}}, a < b};
      OpMfhi:        res = hi_q;
      OpMflo:        res = lo_q;
      OpMthi, OpMtlo: res = a;
      default:       res = a & b;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    dvd_d       = dvd_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    div0_d      = div0_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_nx      = '0;
    prod        = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // The accept edge performs the first iteration, so WIDTH-1 remain.
          case (op)
            OpMult, OpMultu: begin
              state_d  = StMul;
              cnt_d    = SHW'(WIDTH - 2);
              opnd_d   = mag_b;
              acc_d    = mul_step({{WIDTH{1'b0}}, mag_a}, mag_b);
              neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            OpDiv, OpDivu: begin
              state_d  = StDiv;
              cnt_d    = SHW'(WIDTH - 2);
              opnd_d   = mag_b;
              acc_d    = div_step({{WIDTH{1'b0}}, mag_a}, mag_b);
              neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_d = sgn && a[WIDTH-1];
              div0_d   = (b == '0);
              dvd_d    = a;
            end
            default: begin
              out_valid_d = 1'b1;
              result_d    = res;
              zero_d      = (res == '0);
              ovf_d       = ((op == OpAdd) && add_ovf) || ((op == OpSub) && sub_ovf);
              if (op == OpMthi) hi_d = a;
              if (op == OpMtlo) lo_d = a;
            end
          endcase
        end
      end
      StMul: begin
        acc_nx = mul_step(acc_q, opnd_q);
        acc_d  = acc_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          prod        = neg_lo_q ? -acc_nx : acc_nx;
          hi_d        = prod[W2-1:WIDTH];
          lo_d        = prod[WIDTH-1:0];
          state_d     = StIdle;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = '0;
          zero_d      = 1'b1;
          ovf_d       = 1'b0;
        end
      end
      StDiv: begin
        acc_nx = div_step(acc_q, opnd_q);
        acc_d  = acc_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (div0_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = neg_hi_q ? -acc_nx[W2-1:WIDTH] : acc_nx[W2-1:WIDTH];
            lo_d = neg_lo_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
          end
          state_d     = StIdle;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = '0;
          zero_d      = 1'b1;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      dvd_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      dvd_q       <= dvd_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and table-driven bench for alu_exec_unit at WIDTH 32, plus a WIDTH 16 instance
// for multiply/divide latency.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, ovf;
  logic [31:0] hi, lo;

  logic        in_valid_s = 1'b0;
  logic        in_ready_s;
  logic [1:0]  alu_op_s = 2'b10;
  logic [5:0]  funct_s = 6'd0;
  logic [3:0]  shamt_s = 4'd0;
  logic [15:0] a_s = '0, b_s = '0;
  logic        out_valid_s;
  logic [15:0] result_s;
  logic        zero_s, ovf_s;
  logic [15:0] hi_s, lo_s;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf), .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .alu_op(alu_op_s), .funct(funct_s), .shamt(shamt_s), .a(a_s), .b(b_s),
    .out_valid(out_valid_s), .result(result_s), .zero(zero_s), .ovf(ovf_s),
    .hi(hi_s), .lo(lo_s)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        ov;
  } vec_t;

  vec_t vecs[18];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y);
    alu_op = op; funct = f; shamt = sh; a = x; b = y; in_valid = 1'b1;
  endtask

  // Accept edge is the first step; completion must follow WIDTH-1 edges later.
  task automatic run_long(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    int n;
    bit low_ok;
    issue(2'b10, f, 5'd0, x, y);
    step();
    in_valid = 1'b0;
    chk({name, "_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    low_ok = 1'b1;
    while (n < 100) begin
      step();
      n++;
      if (out_valid) break;
      if (in_ready) low_ok = 1'b0;
    end
    chk({name, "_latency"}, 64'(n), 64'(W - 1));
    chk({name, "_stall"}, 64'(low_ok), 64'd1);
    chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({name, "_result"}, 64'({result, zero, ovf}), 64'({32'd0, 1'b1, 1'b0}));
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_long16(input string name, input logic [5:0] f, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] exp_hi,
                            input logic [15:0] exp_lo);
    int n;
    funct_s = f; a_s = x; b_s = y; in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (out_valid_s) break;
    end
    chk({name, "_latency"}, 64'(n), 64'd15);
    chk({name, "_hilo"}, 64'({hi_s, lo_s}), 64'({exp_hi, exp_lo}));
    chk({name, "_ready"}, 64'(in_ready_s), 64'd1);
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] x, input logic [31:0] y);
    case (f)
      6'b100000, 6'b100001: return x + y;
      6'b100010, 6'b100011: return x - y;
      6'b100101: return x | y;
      6'b100110: return x ^ y;
      6'b100111: return ~(x | y);
      6'b000000: return y << sh;
      6'b000010: return y >> sh;
      6'b000011: return $signed(y) >>> sh;
      6'b101010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'b101011: return (x < y) ? 32'd1 : 32'd0;
      default:   return x & y;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] codes[12];
    int seen;
    bit v;
    logic [5:0] f;
    logic [4:0] sh;
    logic [31:0] x, y;

    vecs[0]  = '{2'b10, 6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{2'b10, 6'b100001, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[2]  = '{2'b10, 6'b100010, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{2'b10, 6'b100011, 5'd0,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{2'b00, 6'b111111, 5'd0,  32'h0000000A, 32'h00000014, 32'h0000001E, 1'b0};
    vecs[5]  = '{2'b01, 6'b000000, 5'd0,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[6]  = '{2'b11, 6'b000000, 5'd0,  32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0};
    vecs[7]  = '{2'b10, 6'b100100, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0};
    vecs[8]  = '{2'b10, 6'b100101, 5'd0,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0};
    vecs[9]  = '{2'b10, 6'b100110, 5'd0,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0};
    vecs[10] = '{2'b10, 6'b100111, 5'd0,  32'h00000000, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0};
    vecs[11] = '{2'b10, 6'b000000, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[12] = '{2'b10, 6'b000010, 5'd4,  32'h00000000, 32'hF0000000, 32'h0F000000, 1'b0};
    vecs[13] = '{2'b10, 6'b000011, 5'd4,  32'h00000000, 32'hF0000000, 32'hFF000000, 1'b0};
    vecs[14] = '{2'b10, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[15] = '{2'b10, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[16] = '{2'b10, 6'b111111, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[17] = '{2'b00, 6'b000000, 5'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1};

    codes = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b100111, 6'b000000, 6'b000011, 6'b101010, 6'b111111};

    reset = 1'b1;
    step();
    step();
    chk("rst_outputs", 64'({in_ready, out_valid, zero, ovf}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    issue(2'b10, 6'b010001, 5'd0, 32'h12345678, 32'h0);
    step();
    chk("mthi", 64'({out_valid, result, hi}), 64'({1'b1, 32'h12345678, 32'h12345678}));
    issue(2'b10, 6'b010011, 5'd0, 32'h9ABCDEF0, 32'h0);
    step();
    chk("mtlo", 64'({out_valid, lo}), 64'({1'b1, 32'h9ABCDEF0}));
    issue(2'b10, 6'b010000, 5'd0, 32'h0, 32'h0);
    step();
    chk("mfhi", 64'(result), 64'h12345678);
    issue(2'b10, 6'b010010, 5'd0, 32'h0, 32'h0);
    step();
    chk("mflo", 64'(result), 64'h9ABCDEF0);

    // Back-to-back table: one result per edge.
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].f, vecs[i].sh, vecs[i].x, vecs[i].y);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 64'({zero, ovf}), 64'({vecs[i].res == 32'd0, vecs[i].ov}));
    end
    in_valid = 1'b0;
    step();
    chk("idle_no_valid", 64'(out_valid), 64'd0);

    run_long("mult", 6'b011000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    issue(2'b10, 6'b010010, 5'd0, 32'h0, 32'h0);
    step();
    chk("mflo_after_mult", 64'({out_valid, result}), 64'({1'b1, 32'hFFFFFFF1}));
    in_valid = 1'b0;

    run_long("div", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("div_negdiv", 6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_long("divu_zero", 6'b011011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_long("div_minneg", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_long("multu_max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // Random single-cycle stream with idle gaps.
    for (int i = 0; i < 200; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      f  = codes[$urandom_range(0, 11)];
      sh = 5'($urandom_range(0, 31));
      x  = $urandom;
      y  = $urandom;
      if (v) issue(2'b10, f, sh, x, y);
      else in_valid = 1'b0;
      step();
      chk($sformatf("rnd%0d_valid", i), 64'(out_valid), 64'(v));
      if (v) chk($sformatf("rnd%0d_result", i), 64'(result), 64'(ref_alu(f, sh, x, y)));
    end
    in_valid = 1'b0;

    // Reset in the middle of a multu aborts it.
    issue(2'b10, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'd3);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);

    run_long16("mult16", 6'b011000, 16'hFFFD, 16'd5, 16'hFFFF, 16'hFFF1);
    run_long16("divu16", 6'b011011, 16'd100, 16'd7, 16'd2, 16'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
